// File: rtl/vga_pkg.sv
// Mode timing constants shared by the VGA timing generator and the sync decoder.
// Latency: n/a (constants, types and a pure helper); no backpressure.
// Also defines the decoder lock states and its missing-hsync timeout.
package vga_pkg;

    localparam int HOR_TOTAL_TIME  = 40;
    localparam int HOR_BLANK_START = 24;
    localparam int HOR_BLANK_END   = 39;
    localparam int HOR_SYNC_START  = 30;
    localparam int HOR_SYNC_END    = 33;

    localparam int VER_TOTAL_TIME  = 20;
    localparam int VER_BLANK_START = 16;
    localparam int VER_BLANK_END   = 19;
    localparam int VER_SYNC_START  = 17;
    localparam int VER_SYNC_END    = 18;

    localparam int DEC_TIMEOUT     = 2 * HOR_TOTAL_TIME;

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        LINE   = 2'd1,
        LOCKED = 2'd2
    } dec_state_t;

    function automatic logic in_range(input logic [10:0] v,
                                      input logic [10:0] lo,
                                      input logic [10:0] hi);
        return (v >= lo) && (v <= hi);
    endfunction

endpackage

// File: rtl/sync_edge_det.sv
// Input register plus registered rising-edge pulse for one sync line.
// Latency: sig_q and rise both valid 1 cycle after the input changes.
// Backpressure: none, samples every clock.
module sync_edge_det (
    input  logic clk,
    input  logic rst,
    input  logic sig_in,
    output logic sig_q,
    output logic rise
);

    always_ff @(posedge clk) begin
        if (!rst) begin
            sig_q <= 1'b0;
            rise  <= 1'b0;
        end else begin
            sig_q <= sig_in;
            rise  <= sig_in & ~sig_q;
        end
    end

endmodule

// File: rtl/vga_sync_decoder.sv
// Recovers h/v counters from a sync/blank stream, measures line and frame size, tracks lock.
// Latency: source counter at t appears on hcount/vcount at t+2; all outputs registered.
// Backpressure: none. VGA_DEC_BLANK_CHECK_EN adds blank-vs-prediction checking while LOCKED.
module vga_sync_decoder
    import vga_pkg::*;
#(
    parameter int LOCK_LINES = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        hsync_in,
    input  logic        vsync_in,
    input  logic        hblnk_in,
    input  logic        vblnk_in,
    output logic [10:0] hcount,
    output logic [10:0] vcount,
    output logic        locked,
    output logic        sync_err,
    output logic [11:0] line_len,
    output logic [10:0] frame_lines
);

    localparam logic [10:0] H_LAST    = 11'(HOR_TOTAL_TIME - 1);
    localparam logic [10:0] V_LAST    = 11'(VER_TOTAL_TIME - 1);
    localparam logic [10:0] H_SYNC    = 11'(HOR_SYNC_START);
    localparam logic [10:0] V_SYNC    = 11'(VER_SYNC_START);
    localparam logic [11:0] LINE_NOM  = 12'(HOR_TOTAL_TIME);
    localparam logic [10:0] FRAME_NOM = 11'(VER_TOTAL_TIME);
    localparam logic [11:0] TMO       = 12'(DEC_TIMEOUT);
    localparam int          RUN_W     = $clog2(LOCK_LINES + 1);
    localparam logic [RUN_W-1:0] RUN_LAST = RUN_W'(LOCK_LINES - 1);

    logic hs_q, hs_rise;
    logic vs_q, vs_rise;

    sync_edge_det u_hs_det (
        .clk    (clk),
        .rst    (rst),
        .sig_in (hsync_in),
        .sig_q  (hs_q),
        .rise   (hs_rise)
    );

    sync_edge_det u_vs_det (
        .clk    (clk),
        .rst    (rst),
        .sig_in (vsync_in),
        .sig_q  (vs_q),
        .rise   (vs_rise)
    );

    logic sync_unused;
    assign sync_unused = hs_q | vs_q;

    // Blank inputs need two stages to line up with the recovered counters.
    logic blank_err;
`ifdef VGA_DEC_BLANK_CHECK_EN
    logic hb_q, hb_qq, vb_q, vb_qq;

    always_ff @(posedge clk) begin
        if (!rst) begin
            hb_q  <= 1'b0;
            hb_qq <= 1'b0;
            vb_q  <= 1'b0;
            vb_qq <= 1'b0;
        end else begin
            hb_q  <= hblnk_in;
            hb_qq <= hb_q;
            vb_q  <= vblnk_in;
            vb_qq <= vb_q;
        end
    end

    assign blank_err =
        (in_range(hcount, 11'(HOR_BLANK_START), 11'(HOR_BLANK_END)) != hb_qq) ||
        (in_range(vcount, 11'(VER_BLANK_START), 11'(VER_BLANK_END)) != vb_qq);
`else
    logic blank_unused;
    assign blank_unused = hblnk_in | vblnk_in;
    assign blank_err    = 1'b0;
`endif

    logic [11:0] per_cnt;
    logic        tmo_flag;
    logic [10:0] line_cnt;
    logic [10:0] lines_closing;
    logic        timeout, good_line, bad_line, good_frame;

    assign timeout       = (per_cnt == TMO) && !hs_rise;
    assign good_line     = hs_rise && !tmo_flag && (per_cnt == LINE_NOM);
    assign bad_line      = (hs_rise && !good_line) || timeout;
    // An hsync edge coincident with vsync belongs to the frame being closed.
    assign lines_closing = (hs_rise && (line_cnt != 11'h7FF)) ? line_cnt + 11'd1 : line_cnt;
    assign good_frame    = (lines_closing == FRAME_NOM);

    always_ff @(posedge clk) begin
        if (!rst) begin
            per_cnt     <= '0;
            tmo_flag    <= 1'b0;
            line_len    <= '0;
            line_cnt    <= '0;
            frame_lines <= '0;
        end else begin
            if (hs_rise) begin
                per_cnt  <= 12'd1;
                tmo_flag <= 1'b0;
                if (!tmo_flag)
                    line_len <= per_cnt;
            end else begin
                if (per_cnt != 12'hFFF)
                    per_cnt <= per_cnt + 12'd1;
                if (timeout)
                    tmo_flag <= 1'b1;
            end
            if (vs_rise) begin
                frame_lines <= lines_closing;
                line_cnt    <= '0;
            end else begin
                line_cnt    <= lines_closing;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            hcount <= '0;
            vcount <= '0;
        end else if (vs_rise) begin
            hcount <= '0;
            vcount <= V_SYNC;
        end else if (hs_rise) begin
            hcount <= H_SYNC;
        end else if (hcount >= H_LAST) begin
            hcount <= '0;
            vcount <= (vcount >= V_LAST) ? 11'd0 : vcount + 11'd1;
        end else begin
            hcount <= hcount + 11'd1;
        end
    end

    dec_state_t       state, state_nxt;
    logic [RUN_W-1:0] run_cnt, run_nxt;
    logic             armed, armed_nxt;
    logic             err_nxt;

    always_comb begin
        state_nxt = state;
        run_nxt   = run_cnt;
        armed_nxt = armed;
        err_nxt   = 1'b0;
        case (state)
            SEARCH: begin
                if (bad_line) begin
                    run_nxt = '0;
                end else if (good_line) begin
                    if (run_cnt == RUN_LAST) begin
                        state_nxt = LINE;
                        run_nxt   = '0;
                        armed_nxt = 1'b0;
                    end else begin
                        run_nxt = run_cnt + RUN_W'(1);
                    end
                end
            end
            LINE: begin
                if (bad_line) begin
                    state_nxt = SEARCH;
                    run_nxt   = '0;
                end else if (vs_rise) begin
                    // First vsync only starts a full-frame measurement.
                    if (armed && good_frame)
                        state_nxt = LOCKED;
                    armed_nxt = 1'b1;
                end
            end
            LOCKED: begin
                if (bad_line || blank_err || (vs_rise && !good_frame)) begin
                    state_nxt = SEARCH;
                    run_nxt   = '0;
                    err_nxt   = 1'b1;
                end
            end
            default: begin
                state_nxt = SEARCH;
                run_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= SEARCH;
            run_cnt  <= '0;
            armed    <= 1'b0;
            locked   <= 1'b0;
            sync_err <= 1'b0;
        end else begin
            state    <= state_nxt;
            run_cnt  <= run_nxt;
            armed    <= armed_nxt;
            locked   <= (state_nxt == LOCKED);
            sync_err <= err_nxt;
        end
    end

endmodule

// File: doc/vga_sync_decoder.md
# vga_sync_decoder

Sink-side counterpart of the VGA timing generator. Takes an hsync/vsync/hblnk/vblnk stream, recovers the horizontal and vertical pixel counters, measures line length and frame height, and reports lock against the `vga_pkg` mode. Used as the front end of capture/overlay paths fed by a timing generator output, and as a self-check monitor on our own timing generator.

## Interface
- `LOCK_LINES`, default 4: consecutive nominal lines required to leave SEARCH.
- `clk` input, 1 bit: pixel clock.
- `rst` input, 1 bit: reset, synchronous, active-low.
- `hsync_in` input, 1 bit: horizontal sync, active-high.
- `vsync_in` input, 1 bit: vertical sync, active-high.
- `hblnk_in` input, 1 bit: horizontal blank, active-high.
- `vblnk_in` input, 1 bit: vertical blank, active-high.
- `hcount` output, 11 bits: recovered horizontal count.
- `vcount` output, 11 bits: recovered vertical count.
- `locked` output, 1 bit: stream matches the nominal mode.
- `sync_err` output, 1 bit: one-cycle pulse on loss of lock.
- `line_len` output, 12 bits: last measured hsync rising-edge spacing in clk cycles.
- `frame_lines` output, 11 bits: last measured number of hsync rising edges between vsync rising edges.

## Operation
- All inputs are registered once (`*_q`). A rising edge is `*_in` high with `*_q` low.
- Tracking counters:
  - `hcount` free-runs, wrapping at `HOR_TOTAL_TIME-1` to 0.
  - `vcount` increments on the `hcount` wrap and wraps at `VER_TOTAL_TIME-1`.
  - On an hsync rising edge, `hcount` loads `HOR_SYNC_START`.
  - On a vsync rising edge, `hcount` loads 0 and `vcount` loads `VER_SYNC_START`.
  - If both edges fall in the same cycle, vsync wins for `hcount`.
  - Reloads happen in every state.
- Line measurement:
  - A 12-bit period counter increments each cycle and saturates at 4095.
  - On an hsync edge, `line_len` takes the number of cycles since the previous edge (nominal value `HOR_TOTAL_TIME`), and the counter restarts.
- Frame measurement:
  - An 11-bit counter counts hsync edges and saturates at 2047.
  - On a vsync edge, `frame_lines` takes the count and the counter clears.
  - An hsync edge in the same cycle as a vsync edge counts toward the closing frame.
- A line is good when the measured spacing equals `HOR_TOTAL_TIME`. A frame is good when the measured line count equals `VER_TOTAL_TIME`.
- State machine:
  - SEARCH → LINE after `LOCK_LINES` consecutive good lines. A bad line resets the run count.
  - LINE: the first vsync edge arms frame measurement. On the next vsync edge, a good frame → LOCKED and a bad frame re-arms. Any bad line → SEARCH.
  - LOCKED: a bad line, a bad frame or a timeout → SEARCH with a `sync_err` pulse.
- Timeout: the period counter reaching `2*HOR_TOTAL_TIME` without an hsync edge forces SEARCH. It pulses `sync_err` only if the block was LOCKED. Lines cut short by a timeout are not latched into `line_len`.
- `locked` is high exactly in LOCKED.

## Timing
- All outputs are registered.
- Reset value is 0 for every output; the state resets to SEARCH and all internal counters to 0.
- A reset asserted mid-stream clears everything on the next edge. Recovery always restarts from SEARCH.
- Latency: the source's counter value at cycle t appears on `hcount`/`vcount` at t+2. Input register plus output register.
- An hsync edge whose source `hcount` is `HOR_SYNC_START` produces `hcount == HOR_SYNC_START` two cycles later.
- `line_len` and `frame_lines` update on the same cycle as the corresponding reload.
- Lock transitions take effect on that same edge:
  - `locked` rises on the cycle `hcount`/`vcount` reload from the validating vsync edge.
  - On the cycle a bad edge is detected, `locked` drops and `sync_err` is high for exactly 1 cycle.

## Configuration
- `VGA_DEC_BLANK_CHECK_EN` defined: in LOCKED, a blank mismatch is a lock-loss event, identical to a bad line.
  - Predicted `hblnk` = recovered `hcount` in [`HOR_BLANK_START`, `HOR_BLANK_END`].
  - Predicted `vblnk` = recovered `vcount` in [`VER_BLANK_START`, `VER_BLANK_END`].
  - These are compared each cycle against `hblnk_in`/`vblnk_in` delayed to the same alignment.
- Undefined: `hblnk_in`/`vblnk_in` are ignored, and the ports remain.

## Structure
- `vga_pkg` supplies `HOR_TOTAL_TIME`, `HOR_SYNC_START`, `HOR_BLANK_START/END`, `VER_TOTAL_TIME`, `VER_SYNC_START`, `VER_BLANK_START/END`.
- Add to `vga_pkg`: the `dec_state_t` enum (SEARCH, LINE, LOCKED) and `DEC_TIMEOUT = 2*HOR_TOTAL_TIME`.
- Sub-module `sync_edge_det`: input register plus rising-edge pulse. Instantiated twice, for hsync and vsync.

## Test plan
- Reset held low for 5 cycles with random inputs → all outputs 0 and state SEARCH throughout.
- Source is `vga_timing`, reset released → `locked` rises within `LOCK_LINES` lines + 2 frames. Thereafter `hcount`/`vcount` equal the source counters delayed by 2 cycles, `line_len=HOR_TOTAL_TIME` and `frame_lines=VER_TOTAL_TIME`, with no `sync_err` over 3 frames.
- In LOCKED, one hsync edge injected 10 cycles early → `line_len=HOR_TOTAL_TIME-10`, one `sync_err` cycle, `locked=0`, relock after `LOCK_LINES` lines + 2 frames.
- In LOCKED, hsync forced low → `sync_err` pulse and `locked=0` exactly `2*HOR_TOTAL_TIME` cycles after the last edge; `line_len` unchanged.
- In LOCKED, one line removed from a frame → `frame_lines=VER_TOTAL_TIME-1`, `sync_err` pulse on that vsync edge.
- With `VGA_DEC_BLANK_CHECK_EN`: `hblnk_in` inverted for 1 cycle in LOCKED → `sync_err` pulse. Without the macro, the same stimulus → no error and `locked` stays 1.
